// File: rtl/sync_ctrl_pkg.sv
// Shared definitions for the synchronizer stability supervisor:
// state encoding, counter sizing and parameter clamping.
package sync_ctrl_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ARMED  = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;

  // Bits needed to index 'value' distinct codes (ceil(log2(value))), min 1.
  function automatic int clogb2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) w++;
    if (w < 1) w = 1;
    return w;
  endfunction

  function automatic int clamp_hold(input int hold);
    return (hold < 1) ? 1 : hold;
  endfunction

  function automatic int clamp_timeout(input int timeout, input int hold);
    return (timeout < hold) ? hold : timeout;
  endfunction

  function automatic int clamp_glitch(input int limit);
    return (limit < 1) ? 1 : ((limit > 255) ? 255 : limit);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/sync_stability_controller.sv
// Gates downstream use of synchronized inputs: settles until all monitored
// channels hold stable, then arms and watches for stable-flag drops.
module sync_stability_controller
  import sync_ctrl_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GLITCH_LIMIT   = 3
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enable,
  input  logic            clear,
  input  logic [N_CH-1:0] ch_stable,
  input  logic [N_CH-1:0] ch_mask,
  output logic            armed,
  output logic            fault,
  output logic            fault_timeout,
  output logic            fault_glitch,
  output logic [N_CH-1:0] unstable_ch,
  output logic [7:0]      glitch_count,
  output logic [1:0]      state
);

  localparam int HOLD_C = clamp_hold(HOLD_CYCLES);
  localparam int TO_C   = clamp_timeout(TIMEOUT_CYCLES, HOLD_C);
  localparam int GL_C   = clamp_glitch(GLITCH_LIMIT);
  localparam int HW     = clogb2(HOLD_C + 1);
  localparam int TW     = clogb2(TO_C + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_C - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_C - 1);
  localparam logic [8:0]    GL_LIM    = 9'(GL_C);

  logic [1:0]      state_q, state_d;
  logic            armed_q, fault_q;
  logic            ftmo_q, ftmo_d, fglt_q, fglt_d;
  logic [N_CH-1:0] unst_q, unst_d;
  logic [N_CH-1:0] prev_q;

  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   to_cnt;
  logic [7:0]      gcnt;
  logic            hold_max_unused, to_max_unused, gc_max;

  logic            ok, glitch_ev;
  logic [N_CH-1:0] fall;
  logic [8:0]      gc_inc;

  assign ok   = &(ch_stable | ~ch_mask);
  // Masking uses the current cycle, so a channel unmasked while low never counts.
  assign fall = prev_q & ~ch_stable & ch_mask;
  assign glitch_ev = (state_q == S_ARMED) && enable && !clear && (|fall);
  assign gc_inc = gc_max ? 9'd255 : ({1'b0, gcnt} + 9'd1);

  always_comb begin
    state_d = state_q;
    ftmo_d  = ftmo_q;
    fglt_d  = fglt_q;
    unst_d  = unst_q;
    if (clear) begin
      state_d = S_IDLE;
      ftmo_d  = 1'b0;
      fglt_d  = 1'b0;
      unst_d  = '0;
    end else if (!enable && (state_q != S_FAULT)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SETTLE;
          ftmo_d  = 1'b0;
          fglt_d  = 1'b0;
          unst_d  = '0;
        end
        S_SETTLE: begin
          if (ok && (hold_cnt == HOLD_LAST)) begin
            state_d = S_ARMED;
          end else if (to_cnt == TO_LAST) begin
            state_d = S_FAULT;
            ftmo_d  = 1'b1;
            unst_d  = ch_mask & ~ch_stable;
          end
        end
        S_ARMED: begin
          if (glitch_ev) begin
            unst_d = unst_q | fall;
            if (gc_inc == GL_LIM) begin
              state_d = S_FAULT;
              fglt_d  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.WIDTH(HW), .MAX(HOLD_C)) u_hold_cnt (
    .clk    (clk),
    .rst_n  (resetn),
    .inc    ((state_q == S_SETTLE) && ok),
    .clr    (clear || !enable || (state_q != S_SETTLE) || !ok),
    .count  (hold_cnt),
    .at_max (hold_max_unused)
  );

  sat_counter #(.WIDTH(TW), .MAX(TO_C)) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (resetn),
    .inc    (state_q == S_SETTLE),
    .clr    (clear || (state_q != S_SETTLE)),
    .count  (to_cnt),
    .at_max (to_max_unused)
  );

  // Glitch count survives a drop to IDLE; it restarts on the next settle entry.
  sat_counter #(.WIDTH(8), .MAX(255)) u_glitch_cnt (
    .clk    (clk),
    .rst_n  (resetn),
    .inc    (glitch_ev),
    .clr    (clear || ((state_q == S_IDLE) && enable)),
    .count  (gcnt),
    .at_max (gc_max)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      fault_q <= 1'b0;
      ftmo_q  <= 1'b0;
      fglt_q  <= 1'b0;
      unst_q  <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= (state_d == S_ARMED);
      fault_q <= (state_d == S_FAULT);
      ftmo_q  <= ftmo_d;
      fglt_q  <= fglt_d;
      unst_q  <= unst_d;
      prev_q  <= ch_stable;
    end
  end

  assign armed         = armed_q;
  assign fault         = fault_q;
  assign fault_timeout = ftmo_q;
  assign fault_glitch  = fglt_q;
  assign unstable_ch   = unst_q;
  assign glitch_count  = gcnt;
  assign state         = state_q;

endmodule

// File: tb/tb_sync_stability_controller.sv
// Directed bench for sync_stability_controller (HOLD=16, TIMEOUT=100, LIMIT=3).
module tb_sync_stability_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       enable, clear;
  logic [3:0] ch_stable, ch_mask;
  logic       armed, fault, fault_timeout, fault_glitch;
  logic [3:0] unstable_ch;
  logic [7:0] glitch_count;
  logic [1:0] state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  sync_stability_controller #(
    .N_CH(4), .HOLD_CYCLES(16), .TIMEOUT_CYCLES(100), .GLITCH_LIMIT(3)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
    .ch_stable(ch_stable), .ch_mask(ch_mask),
    .armed(armed), .fault(fault), .fault_timeout(fault_timeout),
    .fault_glitch(fault_glitch), .unstable_ch(unstable_ch),
    .glitch_count(glitch_count), .state(state)
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic [3:0] stab;
    logic [3:0] mask;
    int         n;
    logic [1:0] st;
    logic       arm;
    logic       flt;
    logic       ft;
    logic       fg;
    logic [3:0] unst;
    logic [7:0] gc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic clr, input logic [3:0] stab,
                              input logic [3:0] mask, input int n, input logic [1:0] st,
                              input logic arm, input logic flt, input logic ft,
                              input logic fg, input logic [3:0] unst, input logic [7:0] gc);
    vec_t v;
    v.en = en; v.clr = clr; v.stab = stab; v.mask = mask; v.n = n;
    v.st = st; v.arm = arm; v.flt = flt; v.ft = ft; v.fg = fg; v.unst = unst; v.gc = gc;
    return v;
  endfunction

  function automatic logic [17:0] observed();
    return {state, armed, fault, fault_timeout, fault_glitch, unstable_ch, glitch_count};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got st=%0d arm=%b flt=%b ft=%b fg=%b unst=%b gc=%0d, expected st=%0d arm=%b flt=%b ft=%b fg=%b unst=%b gc=%0d",
               name, got[17:16], got[15], got[14], got[13], got[12], got[11:8], got[7:0],
               exp[17:16], exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
    end
  endtask

  initial begin
    //             en clr stab     mask     n   st   arm flt ft fg unst     gc
    tbl.push_back(mk(0, 0, 4'hF, 4'hF,  2, 2'd0, 0, 0, 0, 0, 4'h0, 8'd0)); // idle
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // enter settle
    tbl.push_back(mk(1, 0, 4'hF, 4'hF, 15, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h0, 8'd0)); // armed at 16
    tbl.push_back(mk(1, 0, 4'hD, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h2, 8'd1)); // glitch 1
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h2, 8'd1));
    tbl.push_back(mk(1, 0, 4'hD, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h2, 8'd2)); // glitch 2
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h2, 8'd2));
    tbl.push_back(mk(1, 0, 4'hD, 4'hF,  1, 2'd3, 0, 1, 0, 1, 4'h2, 8'd3)); // glitch 3 -> fault
    tbl.push_back(mk(0, 0, 4'hF, 4'hF,  3, 2'd3, 0, 1, 0, 1, 4'h2, 8'd3)); // fault ignores enable
    tbl.push_back(mk(1, 1, 4'hF, 4'hF,  1, 2'd0, 0, 0, 0, 0, 4'h0, 8'd0)); // clear
    tbl.push_back(mk(1, 1, 4'hF, 4'hF,  2, 2'd0, 0, 0, 0, 0, 4'h0, 8'd0)); // clear beats enable
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // settle after clear
    tbl.push_back(mk(1, 0, 4'hF, 4'hF, 10, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // hold=10
    tbl.push_back(mk(1, 0, 4'hB, 4'hF,  1, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // ok drops
    tbl.push_back(mk(1, 0, 4'hF, 4'hF, 15, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h0, 8'd0)); // 16 after ok returns
    tbl.push_back(mk(1, 0, 4'hA, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h5, 8'd1)); // two channels, one event
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h5, 8'd1));
    tbl.push_back(mk(1, 0, 4'hE, 4'hE,  1, 2'd2, 1, 0, 0, 0, 4'h5, 8'd1)); // masked drop
    tbl.push_back(mk(1, 0, 4'hE, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h5, 8'd1)); // unmask while low
    tbl.push_back(mk(0, 0, 4'hF, 4'hF,  1, 2'd0, 0, 0, 0, 0, 4'h5, 8'd1)); // disable keeps sticky
    tbl.push_back(mk(1, 0, 4'hB, 4'hF,  1, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // entry zeroes sticky
    tbl.push_back(mk(1, 0, 4'hB, 4'hF, 99, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // one short of timeout
    tbl.push_back(mk(1, 0, 4'hB, 4'hF,  1, 2'd3, 0, 1, 1, 0, 4'h4, 8'd0)); // timeout at 100
    tbl.push_back(mk(1, 1, 4'hB, 4'hF,  1, 2'd0, 0, 0, 0, 0, 4'h0, 8'd0)); // clear fault
    tbl.push_back(mk(1, 0, 4'hB, 4'hB,  1, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0)); // ch2 masked off
    tbl.push_back(mk(1, 0, 4'hB, 4'hB, 15, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hB, 4'hB,  1, 2'd2, 1, 0, 0, 0, 4'h0, 8'd0)); // arms instead
    tbl.push_back(mk(0, 0, 4'hB, 4'hF,  1, 2'd0, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hB, 4'hF,  1, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hB, 4'hF, 84, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hF, 4'hF, 15, 2'd1, 0, 0, 0, 0, 4'h0, 8'd0));
    tbl.push_back(mk(1, 0, 4'hF, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h0, 8'd0)); // arm beats timeout
    tbl.push_back(mk(1, 0, 4'hB, 4'hF,  1, 2'd2, 1, 0, 0, 0, 4'h4, 8'd1));

    resetn = 1'b0; enable = 1'b0; clear = 1'b0; ch_stable = 4'h0; ch_mask = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", observed(), 18'h0);
    resetn = 1'b1;

    foreach (tbl[i]) begin
      enable = tbl[i].en; clear = tbl[i].clr; ch_stable = tbl[i].stab; ch_mask = tbl[i].mask;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      check($sformatf("row%0d", i), observed(),
            {tbl[i].st, tbl[i].arm, tbl[i].flt, tbl[i].ft, tbl[i].fg, tbl[i].unst, tbl[i].gc});
    end

    // Asynchronous reset while armed with sticky status set.
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async_reset", observed(), 18'h0);
    @(posedge clk);
    #1;
    enable = 1'b0; ch_stable = 4'hF; ch_mask = 4'hF;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", observed(), 18'h0);

    // Cycle-exact arm: SETTLE from the first edge, ARMED on the 17th.
    enable = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("arm_cycle%0d", k), observed(),
            {(k < 17) ? 2'd1 : 2'd2, (k == 17), 1'b0, 1'b0, 1'b0, 4'h0, 8'd0});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
